// File: rtl/seg_pkg.sv
// Shared seven-segment display types, constants and helpers.
// lz_show_mask backs the optional SEG_SCAN_LZ_BLANK_EN leading-zero blanking.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] CSN_ALL_OFF = 8'hFF;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'b0000000;

    // Segment order a..g maps to bits 6..0
    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1111011;
    localparam seg_t SEG_A = 7'b1110111;
    localparam seg_t SEG_B = 7'b0011111;
    localparam seg_t SEG_C = 7'b1001110;
    localparam seg_t SEG_D = 7'b0111101;
    localparam seg_t SEG_E = 7'b1001111;
    localparam seg_t SEG_F = 7'b1000111;

    function automatic seg_t hex_to_seg(input nibble_t n);
        seg_t s;
        case (n)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = SEG_A;
            4'hB: s = SEG_B;
            4'hC: s = SEG_C;
            4'hD: s = SEG_D;
            4'hE: s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

    // Bit i set means digit i is lit; digit 0 is always lit so zero reads "0"
    function automatic logic [NUM_DIGITS-1:0] lz_show_mask(input logic [4*NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] m;
        logic seen;
        m    = '0;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen = seen | (v[4*i +: 4] != 4'h0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to a..g segment decoder, shared by display blocks.
module seg_hex_decode
    import seg_pkg::*;
(
    input  nibble_t nib,
    output seg_t    seg
);

    assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with frame-aligned value updates.
// Optional leading-zero blanking when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        upd_valid,
    input  logic [31:0] upd_data,
    output logic        upd_ready,
    output logic [7:0]  num_csn,
    output logic [6:0]  num_a_g,
    output logic        frame_done
);

    localparam int TW = $clog2(SCAN_DIV);

    logic [TW-1:0] tick;
    logic [2:0]    dig;
    logic [31:0]   shown;
    logic [31:0]   pend;
    logic          pend_valid;

    logic    wrap;
    logic    commit;
    logic    accept;
    logic    blank;
    logic    dig_on;
    nibble_t cur_nib;
    seg_t    cur_seg;

    assign wrap      = (tick == TW'(SCAN_DIV - 1));
    assign commit    = wrap && (dig == 3'd7) && pend_valid;
    assign upd_ready = !pend_valid;
    assign accept    = upd_valid && upd_ready;
    assign blank     = (tick < TW'(BLANK_CYC));
    assign cur_nib   = shown[{dig, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // Mask follows shown, so it only moves at commit time
    logic [NUM_DIGITS-1:0] show_mask;

    always_ff @(posedge clk) begin
        if (!resetn)
            show_mask <= 8'h01;
        else if (commit)
            show_mask <= lz_show_mask(pend);
    end

    assign dig_on = show_mask[dig];
`else
    assign dig_on = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick       <= '0;
            dig        <= '0;
            shown      <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            frame_done <= 1'b0;
            num_csn    <= CSN_ALL_OFF;
            num_a_g    <= SEG_OFF;
        end else begin
            tick       <= wrap ? '0 : tick + 1'b1;
            frame_done <= wrap && (dig == 3'd7);
            if (wrap)
                dig <= dig + 3'd1;

            // accept needs !pend_valid and commit needs pend_valid: never both
            if (commit) begin
                shown      <= pend;
                pend_valid <= 1'b0;
            end else if (accept) begin
                pend       <= upd_data;
                pend_valid <= 1'b1;
            end

            if (blank) begin
                num_csn <= CSN_ALL_OFF;
                num_a_g <= SEG_OFF;
            end else begin
                num_csn <= ~(8'h80 >> dig);
                num_a_g <= dig_on ? cur_seg : SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-level model queues per-cycle expectations.
module tb_seg_scan_ctrl;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = SD * 8;

    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        logic [7:0] csn;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_data = '0;
    logic        upd_ready;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];

    // model state: cycles since reset release, displayed value, one-slot mailbox
    int          n = 0;
    int          gcyc = 0;
    logic [31:0] disp = '0;
    logic [31:0] mbox = '0;
    logic        full = 1'b0;
    logic        acc = 1'b0;

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .num_csn    (num_csn),
        .num_a_g    (num_a_g),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] digit_seg(input logic [31:0] v, input int d);
        logic [31:0] hi;
        hi = v >> (4 * d);
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (d != 0 && hi == 32'd0)
            return 7'b0;
`endif
        return HEX[hi[3:0]];
    endfunction

    task automatic model_step();
        exp_t e;
        int   slot_t;
        int   d;
        logic last;
        e.cyc = gcyc;
        gcyc++;
        if (!resetn) begin
            n = 0; disp = '0; full = 1'b0;
            e.csn = 8'hFF; e.seg = 7'b0; e.fd = 1'b0; e.rdy = 1'b1;
        end else begin
            slot_t = n % SD;
            d      = (n / SD) % 8;
            last   = ((n % FRAME) == FRAME - 1);
            if (slot_t < BC) begin
                e.csn = 8'hFF; e.seg = 7'b0;
            end else begin
                e.csn = 8'hFF & ~(8'h80 >> d);
                e.seg = digit_seg(disp, d);
            end
            e.fd = last;
            if (last && full) begin
                disp = mbox; full = 1'b0;
            end else if (upd_valid && !full) begin
                mbox = upd_data; full = 1'b1; acc = 1'b1;
            end
            e.rdy = !full;
            n++;
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic offer(input logic [31:0] v);
        int t;
        t = 0;
        acc = 1'b0;
        upd_valid = 1'b1;
        upd_data = v;
        while (!acc && t < 300) begin
            step();
            t++;
        end
        if (!acc) begin
            checks++; failures++;
            $display("FAIL offer_timeout value=%h not accepted within %0d cycles", v, t);
        end
    endtask

    // monitor: every cycle presents an output word, compare against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (num_csn !== e.csn) begin
                    failures++;
                    $display("FAIL csn cyc=%0d got=%h want=%h", e.cyc, num_csn, e.csn);
                end
                checks++;
                if (num_a_g !== e.seg) begin
                    failures++;
                    $display("FAIL a_g cyc=%0d got=%b want=%b", e.cyc, num_a_g, e.seg);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    failures++;
                    $display("FAIL frame_done cyc=%0d got=%b want=%b", e.cyc, frame_done, e.fd);
                end
                checks++;
                if (upd_ready !== e.rdy) begin
                    failures++;
                    $display("FAIL upd_ready cyc=%0d got=%b want=%b", e.cyc, upd_ready, e.rdy);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        run(3);
        resetn = 1'b1;
        run(40);

        offer(32'h89ABCDEF);
        upd_valid = 1'b0;
        run(80);

        offer(32'h11111111);
        offer(32'h22222222);
        upd_valid = 1'b0;
        run(100);

        for (int i = 0; i < 600; i++) begin
            upd_valid = 1'($urandom_range(0, 1));
            upd_data  = $urandom;
            step();
        end
        upd_valid = 1'b0;
        run(70);

        // pending value must vanish across a reset before its commit
        resetn = 1'b0;
        run(2);
        resetn = 1'b1;
        offer(32'h12345678);
        upd_valid = 1'b0;
        run(5);
        resetn = 1'b0;
        run(2);
        resetn = 1'b1;
        run(70);

        offer(32'h00000305);
        upd_valid = 1'b0;
        run(70);
        offer(32'h00000000);
        upd_valid = 1'b0;
        run(70);
        offer(32'hF0000000);
        upd_valid = 1'b0;
        run(70);

        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
